// File: rtl/bta_serial_reduce_ctrl.sv
// Time-multiplexed multi-operand adder: loads N operands, then reduces them
// pairwise through one shared W-bit adder in binary-tree order, level by level.
module bta_serial_reduce_ctrl #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 16,
    localparam int unsigned W = M + $clog2(N),
    localparam int unsigned LW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [M-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_sum,
    output logic          busy,
    output logic [LW-1:0] level
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t state_q, state_nxt;

    logic [W-1:0]  opbuf_q [N];
    logic [LW-1:0] cnt_q;
    logic [LW-1:0] k_q;
    logic [LW-1:0] lvl_q;

    logic [LW-1:0] lo_idx_c;
    logic [LW-1:0] hi_idx_c;
    logic [W-1:0]  sum_c;
    logic          last_pair_c;
    logic          last_level_c;
    logic          load_last_c;

    // Pair k of the current level reads entries 2k and 2k+1 and writes entry k.
    assign lo_idx_c     = LW'({1'b0, k_q} << 1);
    assign hi_idx_c     = lo_idx_c | LW'(1);
    assign sum_c        = opbuf_q[lo_idx_c] + opbuf_q[hi_idx_c];
    assign last_pair_c  = (k_q == LW'((N >> (lvl_q + LW'(1))) - 1));
    assign last_level_c = (lvl_q == LW'(LW - 1));
    assign load_last_c  = in_valid && (cnt_q == LW'(N - 1));
    assign level        = lvl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_LOAD: begin
                if (load_last_c) begin
                    state_nxt = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (last_pair_c && last_level_c) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Datapath, counters and registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                opbuf_q[i] <= '0;
            end
            cnt_q     <= '0;
            k_q       <= '0;
            lvl_q     <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            in_ready <= (state_nxt == ST_LOAD);
            busy     <= (state_nxt != ST_LOAD);
            case (state_q)
                ST_LOAD: begin
                    k_q   <= '0;
                    lvl_q <= '0;
                    if (in_valid) begin
                        opbuf_q[cnt_q] <= W'(in_data);
                        cnt_q          <= cnt_q + LW'(1);
                    end
                end
                ST_REDUCE: begin
                    opbuf_q[k_q] <= sum_c;
                    if (last_pair_c) begin
                        k_q <= '0;
                        if (last_level_c) begin
                            out_sum   <= sum_c;
                            out_valid <= 1'b1;
                            lvl_q     <= '0;
                        end else begin
                            lvl_q <= lvl_q + LW'(1);
                        end
                    end else begin
                        k_q <= k_q + LW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bta_serial_reduce_ctrl.sv
// Randomized self-checking bench for bta_serial_reduce_ctrl against a
// frame-level arithmetic model (sum of accepted operands, tree level schedule).
module tb_bta_serial_reduce_ctrl;

    localparam int N  = 16;
    localparam int M  = 16;
    localparam int W  = 20;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [M-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          busy;
    logic [LW-1:0] level;

    bta_serial_reduce_ctrl #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy),
        .level     (level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [M-1:0] ops [N];
    int           lv_trace [N];
    logic [W-1:0] buf0_probe;
    logic [W-1:0] res_sum;
    int           res_lat;
    int           res_low;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected frame sum: plain integer addition of the operands.
    function automatic logic [W-1:0] ref_sum();
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(ops[i]);
        return W'(s);
    endfunction

    // Tree level of the c-th reduce cycle: level L holds N/2^(L+1) pairs.
    function automatic int ref_level(input int c);
        int l = 0;
        int rem = c;
        while (rem >= (N >> (l + 1))) begin
            rem -= (N >> (l + 1));
            l++;
        end
        return l;
    endfunction

    // gap_mode: 0 continuous, 1 in_valid pattern 1,0,0,..., 2 random gaps.
    task automatic load_frame(input int gap_mode);
        int  beat = 0;
        int  guard;
        bit  v;
        bit  hs;
        for (int i = 0; i < N; i++) begin
            guard = 0;
            forever begin
                case (gap_mode)
                    0:       v = 1'b1;
                    1:       v = ((beat % 3) == 0);
                    default: v = ($urandom_range(0, 2) != 0);
                endcase
                beat++;
                in_valid = v;
                in_data  = v ? ops[i] : M'($urandom);
                hs = v && in_ready;
                cycle();
                if (hs) break;
                guard++;
                if (guard > 50) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL load_timeout op=%0d in_ready=%b required 1", i, in_ready);
                    break;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Called in the cycle after the last accept; returns at the first out_valid cycle.
    task automatic wait_result();
        int c = 0;
        res_lat = 1;
        res_low = 0;
        for (int i = 0; i < N; i++) lv_trace[i] = -1;
        while (out_valid !== 1'b1 && res_lat < 200) begin
            if (in_ready === 1'b0) res_low++;
            if (c < N) lv_trace[c] = int'(level);
            if (c == N / 2) buf0_probe = dut.opbuf_q[0];
            c++;
            cycle();
            res_lat++;
        end
        if (out_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL result_timeout out_valid=%b required 1", out_valid);
        end
        if (in_ready === 1'b0) res_low++;
        res_sum = out_sum;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
        n_checks++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum got=%h required=0", out_sum); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b required=0", busy); end
        n_checks++; if (level !== '0) begin n_fail++; $display("FAIL reset_level got=%0d required=0", level); end
    endtask

    task automatic test_ramp();
        logic [W-1:0] exp_buf0;
        for (int i = 0; i < N; i++) ops[i] = M'(i + 1);
        exp_buf0 = W'(ops[0]) + W'(ops[1]);
        out_ready = 1'b1;
        load_frame(0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ramp_busy got=%b required=1", busy); end
        wait_result();
        n_checks++; if (res_sum !== W'(136)) begin n_fail++; $display("FAIL ramp_sum got=%h required=%h", res_sum, W'(136)); end
        n_checks++; if (res_lat != N) begin n_fail++; $display("FAIL ramp_latency got=%0d required=%0d", res_lat, N); end
        n_checks++; if (res_low != N) begin n_fail++; $display("FAIL ramp_in_ready_low got=%0d required=%0d", res_low, N); end
        n_checks++; if (level !== '0) begin n_fail++; $display("FAIL done_level got=%0d required=0", level); end
        for (int c = 0; c < N - 1; c++) begin
            n_checks++;
            if (lv_trace[c] != ref_level(c)) begin
                n_fail++;
                $display("FAIL level_trace cycle=%0d got=%0d required=%0d", c, lv_trace[c], ref_level(c));
            end
        end
        n_checks++; if (buf0_probe !== exp_buf0) begin n_fail++; $display("FAIL buf0_after_level0 got=%h required=%h", buf0_probe, exp_buf0); end
        cycle();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_valid_drop got=%b required=0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ramp_in_ready_back got=%b required=1", in_ready); end
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < N; i++) ops[i] = 16'hFFFF;
        out_ready = 1'b1;
        load_frame(0);
        wait_result();
        n_checks++; if (res_sum !== 20'hFFFF0) begin n_fail++; $display("FAIL all_ones_sum got=%h required=%h", res_sum, 20'hFFFF0); end
        cycle();
    endtask

    task automatic test_gaps();
        for (int i = 0; i < N; i++) ops[i] = 16'h1234;
        out_ready = 1'b1;
        load_frame(1);
        wait_result();
        n_checks++; if (res_sum !== 20'h12340) begin n_fail++; $display("FAIL gaps_sum got=%h required=%h", res_sum, 20'h12340); end
        n_checks++; if (res_lat != N) begin n_fail++; $display("FAIL gaps_latency got=%0d required=%0d", res_lat, N); end
        cycle();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp;
        for (int i = 0; i < N; i++) ops[i] = M'($urandom);
        exp = ref_sum();
        out_ready = 1'b0;
        load_frame(2);
        wait_result();
        n_checks++; if (res_sum !== exp) begin n_fail++; $display("FAIL bp_sum got=%h required=%h", res_sum, exp); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = M'($urandom);
            cycle();
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== exp || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d valid=%b sum=%h in_ready=%b required 1/%h/0", i, out_valid, out_sum, in_ready, exp);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b required=0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b required=1", in_ready); end
        for (int i = 0; i < N; i++) ops[i] = 16'h0002;
        out_ready = 1'b1;
        load_frame(0);
        wait_result();
        n_checks++; if (res_sum !== 20'h00020) begin n_fail++; $display("FAIL bp_next_sum got=%h required=%h", res_sum, 20'h00020); end
        cycle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N; i++) ops[i] = M'($urandom);
        out_ready = 1'b1;
        load_frame(0);
        repeat (7) cycle();
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b required=0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got=%b required=1", in_ready); end
        n_checks++; if (level !== '0) begin n_fail++; $display("FAIL rst_mid_level got=%0d required=0", level); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b required=0", busy); end
        cycle();
        rst = 1'b0;
        cycle();
        for (int i = 0; i < N; i++) ops[i] = M'(i + 1);
        load_frame(0);
        wait_result();
        n_checks++; if (res_sum !== 20'h00088) begin n_fail++; $display("FAIL rst_mid_clean_sum got=%h required=%h", res_sum, 20'h00088); end
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp;
        int bp;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       ops[i] = 16'hFFFF;
                    1:       ops[i] = 16'h0000;
                    default: ops[i] = M'($urandom);
                endcase
            end
            exp = ref_sum();
            out_ready = 1'b0;
            load_frame(2);
            wait_result();
            n_checks++; if (res_sum !== exp) begin n_fail++; $display("FAIL rand_sum frame=%0d got=%h required=%h", f, res_sum, exp); end
            n_checks++; if (res_lat != N) begin n_fail++; $display("FAIL rand_latency frame=%0d got=%0d required=%0d", f, res_lat, N); end
            bp = $urandom_range(0, 3);
            repeat (bp) cycle();
            out_ready = 1'b1;
            cycle();
            out_ready = 1'b0;
            n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rand_release frame=%0d valid=%b in_ready=%b required 0/1", f, out_valid, in_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_all_ones();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
